mult128_stream_wrapper: RTL
===========================

Name: mult128_stream_wrapper

Overview:
Sequential operand loader and result drainer for the 128x128 combinational multiplier core. Accepts 32-bit words on a valid/ready input stream and assembles the two 128-bit operands. Drives them to the core, waits a fixed settle time, then captures the 256-bit product. Streams the product out as eight 32-bit words on a valid/ready output stream. Sits directly between the system bus adapter and the multiplier.

Parameters:
WORD_W, 32, stream word width; OP_W must be an exact multiple
OP_W, 128, operand width; product width is 2*OP_W
MUL_LATENCY, 1, clock edges allowed for the core to settle before the product is sampled; must be >= 1

Ports:
clk  input  1  clock; all state updates on its rising edge
rst  input  1  asynchronous, active-high reset
in_data  input  WORD_W  operand word
in_valid  input  1  in_data is valid
in_ready  output  1  block accepts a word this cycle
mul_a  output  OP_W  operand A to the multiplier core
mul_b  output  OP_W  operand B to the multiplier core
mul_product  input  2*OP_W  product from the multiplier core
out_data  output  WORD_W  product word
out_valid  output  1  out_data is valid
out_ready  input  1  downstream accepts out_data
out_last  output  1  high with the final (8th) product word
busy  output  1  high from the first accepted word until the last output handshake

Behaviour:
- Input transfer: on a clock edge where in_valid && in_ready.
- Output transfer: on a clock edge where out_valid && out_ready.
- Word order, input: 4 words of A, then 4 words of B, least-significant word first.
  - Word k (0..3) is written to mul_a[32k+31:32k].
  - Word k (4..7) is written to mul_b[32(k-4)+31:32(k-4)].
- Word order, output: product words least-significant first.
- FSM states: LOAD, WAIT, DRAIN.
- LOAD:
  - in_ready=1, out_valid=0.
  - A 3-bit word counter increments per input transfer.
  - On the 8th transfer, go to WAIT with the wait counter at 0.
- WAIT:
  - in_ready=0, out_valid=0.
  - The wait counter increments each edge.
  - On the edge where the counter equals MUL_LATENCY-1, register mul_product into a 256-bit result register and go to DRAIN with the output index at 0.
- DRAIN:
  - in_ready=0, out_valid=1, out_data = result word[index] (registered).
  - out_last = (index==7).
  - While out_ready=0, out_data and out_last hold stable.
  - Each output transfer increments index.
  - The transfer with out_last=1 returns to LOAD and clears all counters.
- Latency: if the 8th input transfer occurs on edge E, the product is sampled at edge E+MUL_LATENCY and out_valid rises just after it. With zero backpressure the first word transfers at E+MUL_LATENCY+1.
- mul_a/mul_b hold their values after the product is captured and are overwritten word-by-word by the next load. The core output is ignored outside WAIT.
- busy = (state!=LOAD) || (word counter != 0).
- in_valid gaps in LOAD simply stall the counter; there is no timeout.
- Reset, asserted at any time including mid-load, WAIT or DRAIN:
  - state=LOAD, all counters 0, mul_a=0, mul_b=0, result register=0.
  - out_valid=0, out_last=0, out_data=0, busy=0.
  - Any partial transaction is discarded; no output words are emitted for it.
  - in_ready is forced to 0 while rst is high.
- Throughput: one multiplication per 8 + MUL_LATENCY + 8 cycles minimum. There is no overlap of load and drain.
- in_valid/in_data presented outside LOAD are ignored (not consumed).

Test Plan:
- Small values, MUL_LATENCY=1: load A words 2,0,0,0 and B words 3,0,0,0 back-to-back.
  - Required: out words 6,0,0,0,0,0,0,0.
  - out_last only on the 8th word.
  - First out_valid edge is 1 cycle after the 8th input transfer edge.
- All-ones operands: A and B words all FFFFFFFF.
  - Required: out words 00000001,0,0,0,FFFFFFFE,FFFFFFFF,FFFFFFFF,FFFFFFFF.
- Shifted operands: A=2^64 (words 0,0,1,0), B=2^64.
  - Required: word 4 = 00000001, all other words 0.
- Output backpressure: hold out_ready=0 for 3 cycles while word 2 is presented.
  - Required: out_data, out_valid and out_last stable throughout.
  - No word skipped or duplicated.
  - in_ready stays 0 until the final handshake.
- Input gaps plus MUL_LATENCY=3: in_valid toggled randomly during load.
  - Required: correct product.
  - Product sampled exactly 3 edges after the 8th transfer.
- Reset mid-load and mid-drain: assert rst after 5 input words, and separately after 3 output words.
  - Required: outputs reset immediately (asynchronous), busy=0, no further words from the aborted transaction.
  - A following full transaction (2x3) returns 6.

Source files
------------

// File: rtl/mult128_stream_wrapper.sv
// mult128_stream_wrapper
//   Loads two OP_W-bit operands from a WORD_W-bit valid/ready stream (A then B,
//   least-significant word first), presents them to an external combinational
//   multiplier, waits MUL_LATENCY edges for it to settle, captures the 2*OP_W
//   product and streams it out least-significant word first.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_data/valid/ready operand word stream (accepted only while loading)
//   mul_a, mul_b        operands driven to the multiplier core
//   mul_product         product returned by the core (sampled in WAIT only)
//   out_data/valid/ready/last  product word stream, out_last on final word
//   busy                high from first accepted word to last output handshake
//
// WORD_W must divide OP_W exactly; MUL_LATENCY must be >= 1.

module mult128_stream_wrapper #(
  parameter int unsigned WORD_W      = 32,
  parameter int unsigned OP_W        = 128,
  parameter int unsigned MUL_LATENCY = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WORD_W-1:0]   in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [OP_W-1:0]     mul_a,
  output logic [OP_W-1:0]     mul_b,
  input  logic [2*OP_W-1:0]   mul_product,
  output logic [WORD_W-1:0]   out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_last,
  output logic                busy
);

  localparam int unsigned OpWords  = OP_W / WORD_W;
  localparam int unsigned InWords  = 2 * OpWords;
  localparam int unsigned OutWords = 2 * OpWords;
  localparam int unsigned CntW     = $clog2(InWords);
  localparam int unsigned WaitW    = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;

  typedef enum logic [1:0] {StLoad, StWait, StDrain} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   word_cnt_q, word_cnt_d;
  logic [CntW-1:0]   idx_q, idx_d;
  logic [WaitW-1:0]  wait_cnt_q, wait_cnt_d;
  logic [OP_W-1:0]   mul_a_q, mul_b_q;
  logic [2*OP_W-1:0] result_q;

  logic in_fire, out_fire, wait_done;

  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign wait_done = (state_q == StWait) && (wait_cnt_q == WaitW'(MUL_LATENCY - 1));
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;

  // State and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StLoad;
      word_cnt_q <= '0;
      idx_q      <= '0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      idx_q      <= idx_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Next-state and counter logic
  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    idx_d      = idx_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      StLoad: begin
        if (in_fire) begin
          if (word_cnt_q == CntW'(InWords - 1)) begin
            word_cnt_d = '0;
            wait_cnt_d = '0;
            state_d    = StWait;
          end else begin
            word_cnt_d = word_cnt_q + 1'b1;
          end
        end
      end
      StWait: begin
        if (wait_done) begin
          wait_cnt_d = '0;
          idx_d      = '0;
          state_d    = StDrain;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      StDrain: begin
        if (out_fire) begin
          if (idx_q == CntW'(OutWords - 1)) begin
            idx_d   = '0;
            state_d = StLoad;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = StLoad;
    endcase
  end

  // Outputs; all decoded from registered state so they hold under backpressure
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    unique case (state_q)
      StLoad:  in_ready = !rst;
      StDrain: begin
        out_valid = 1'b1;
        out_last  = (idx_q == CntW'(OutWords - 1));
        for (int k = 0; k < OutWords; k++) begin
          if (idx_q == CntW'(k)) out_data = result_q[k*WORD_W +: WORD_W];
        end
      end
      default: ;
    endcase
    busy = (state_q != StLoad) || (word_cnt_q != '0);
  end

  // Operand assembly and product capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_a_q  <= '0;
      mul_b_q  <= '0;
      result_q <= '0;
    end else begin
      if (in_fire) begin
        for (int k = 0; k < OpWords; k++) begin
          if (word_cnt_q == CntW'(k))           mul_a_q[k*WORD_W +: WORD_W] <= in_data;
          if (word_cnt_q == CntW'(k + OpWords)) mul_b_q[k*WORD_W +: WORD_W] <= in_data;
        end
      end
      if (wait_done) result_q <= mul_product;
    end
  end

endmodule
